// File: rtl/aes_inv_cipher_pkg.sv
// Shared AES-128 decrypt constants, FSM encodings and GF(2^8) helpers.
// Byte i of a 128-bit state lives at bits 8*i+7:8*i, with i = row + 4*col.
package aes_pkg;

  localparam int NR      = 10;
  localparam int STATE_W = 128;
  localparam int RK_AW   = 4;

  localparam logic [RK_AW-1:0] RK_TOP = RK_AW'(NR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [STATE_W-1:0] inv_mix_columns(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Ciphertext-in / plaintext-out handshakes plus the round-key read port.
interface aes_inv_cipher_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic [RK_AW-1:0]   rk_addr;
  logic [STATE_W-1:0] rk_data;

  modport slave (
    input  in_valid, in_data, out_ready, rk_data,
    output in_ready, out_valid, out_data, rk_addr
  );

  modport master (
    output in_valid, in_data, out_ready, rk_data,
    input  in_ready, out_valid, out_data, rk_addr
  );

endinterface

// File: rtl/aes_inv_cipher_inv_sbox.sv
// Combinational AES inverse S-box; table byte 0 sits in the most significant bits.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] idx;

  assign idx = 11'd2047 - {a, 3'b000};
  assign y   = TABLE[idx -: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, 12 cycles per block.
// Round keys arrive one cycle after rk_addr, which mirrors the round counter directly.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  aes_inv_cipher_if.slave  bus
);

  logic [2:0]         fsm;
  logic [RK_AW-1:0]   rnd;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] ct_q;
  logic [STATE_W-1:0] shifted;
  logic [STATE_W-1:0] subbed;
  logic [STATE_W-1:0] round_out;
  logic [STATE_W-1:0] final_out;

  assign shifted = inv_shift_rows(state);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .a (shifted[8*i +: 8]),
      .y (subbed[8*i +: 8])
    );
  end

  assign round_out = inv_mix_columns(subbed ^ bus.rk_data);
  assign final_out = subbed ^ bus.rk_data;

  // Block FSM, round counter and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= S_IDLE;
      rnd   <= RK_TOP;
      state <= '0;
      ct_q  <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.in_valid) begin
            ct_q <= bus.in_data;
            rnd  <= RK_TOP - 4'd1;
            fsm  <= S_INIT;
          end
        end
        S_INIT: begin
          state <= ct_q ^ bus.rk_data;
          rnd   <= RK_TOP - 4'd2;
          fsm   <= S_ROUND;
        end
        // rnd==0 marks the cycle consuming rk[1]; the counter then holds at 0 so FINAL reads rk[0].
        S_ROUND: begin
          state <= round_out;
          if (rnd == 4'd0) begin
            fsm <= S_FINAL;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        S_FINAL: begin
          state <= final_out;
          rnd   <= RK_TOP;
          fsm   <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            fsm <= S_IDLE;
          end
        end
        default: begin
          fsm <= S_IDLE;
          rnd <= RK_TOP;
        end
      endcase
    end
  end

  assign bus.in_ready  = (fsm == S_IDLE);
  assign bus.out_valid = (fsm == S_DONE);
  assign bus.out_data  = state;
  assign bus.rk_addr   = rnd;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher with a behavioural key store and a plaintext scoreboard.
module tb_aes_inv_cipher;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_inv_cipher_if bus();

  aes_inv_cipher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int key_sel = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] ks [2][11];
  logic [127:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Expanded-key store with one-cycle read latency.
  always @(posedge clk)
    bus.rk_data <= (bus.rk_addr <= 4'd10) ? ks[key_sel][bus.rk_addr] : 128'h0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // FIPS listings print byte 0 first; the DUT keeps byte 0 in the low bits.
  function automatic logic [127:0] fips(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic hi;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      hi = x[7];
      x = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box from the field inverse and affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, input int sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:24], t[23:16], t[15:8]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[7:0] = t[7:0] ^ rcon;
        rcon = gm(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[sel][r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  // Called at a negedge in IDLE; returns at the negedge of T+1 with t0 = cycle T.
  task automatic issue(input logic [127:0] ct, input logic [127:0] pt, output int t0);
    chk("in_ready_idle", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    t0 = cyc;
    @(posedge clk);
    exp_q.push_back(pt);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 128'h0;
  endtask

  task automatic wait_out(input int t0, input int lat, input string tag);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(cyc - t0), 128'(lat));
  endtask

  task automatic take_out(input string tag);
    logic [127:0] e;
    chk({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
    chk({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'h0;
    chk(tag, bus.out_data, e);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 128'(bus.in_ready), 128'd1);
    chk({tag, "_out_valid_after"}, 128'(bus.out_valid), 128'd0);
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    int n;
    int seen;
    logic [127:0] e;

    bus.in_valid  = 1'b0;
    bus.in_data   = 128'h0;
    bus.out_ready = 1'b0;
    build_sbox();
    expand(fips(KEY_C1), 0);
    expand(fips(KEY_B), 1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_rk_addr", 128'(bus.rk_addr), 128'd10);

    // FIPS-197 C.1 with latency check
    key_sel = 0;
    issue(fips(CT_C1), fips(PT_C1), t0);
    wait_out(t0, 12, "c1_latency");
    take_out("c1_pt");

    // FIPS-197 App. B with per-cycle rk_addr trace
    key_sel = 1;
    @(negedge clk);
    chk("b_rk_T", 128'(bus.rk_addr), 128'd10);
    issue(fips(CT_B), fips(PT_B), t0);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("b_rk_T%0d", k), 128'(bus.rk_addr),
          (k <= 10) ? 128'(10 - k) : ((k == 11) ? 128'd0 : 128'd10));
      chk($sformatf("b_ov_T%0d", k), 128'(bus.out_valid), (k == 12) ? 128'd1 : 128'd0);
    end
    take_out("b_pt");

    // Backpressure with an ignored in_valid pulse
    key_sel = 0;
    issue(fips(CT_C1), fips(PT_C1), t0);
    wait_out(t0, 12, "bp_latency");
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_out_data", bus.out_data, (exp_q.size() > 0) ? exp_q[0] : 128'h0);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      if (i == 5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = fips(CT_B);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 128'h0;
      end
      @(negedge clk);
    end
    take_out("bp_pt");
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("bp_no_extra_block", 128'(seen), 128'd0);

    // Back-to-back with in_valid and out_ready held high
    key_sel = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = fips(CT_C1);
    chk("b2b_in_ready1", 128'(bus.in_ready), 128'd1);
    t1 = cyc;
    @(posedge clk);
    exp_q.push_back(fips(PT_C1));
    @(negedge clk);
    bus.in_data = fips(CT_B);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      if (bus.out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'h0;
        chk("b2b_pt1", bus.out_data, e);
        key_sel = 1;
      end
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    chk("b2b_accept_gap", 128'(t2 - t1), 128'd13);
    @(posedge clk);
    exp_q.push_back(fips(PT_B));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 128'h0;
    wait_out(t2, 12, "b2b_latency2");
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'h0;
    chk("b2b_pt2", bus.out_data, e);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b_sb_drained", 128'(exp_q.size()), 128'd0);

    // Reset mid-operation at T+6
    key_sel = 0;
    @(negedge clk);
    issue(fips(CT_C1), fips(PT_C1), t0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mid_rst_rk_addr", 128'(bus.rk_addr), 128'd10);
    chk("mid_rst_out_data", bus.out_data, 128'h0);
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("mid_rst_no_out", 128'(seen), 128'd0);
    issue(fips(CT_C1), fips(PT_C1), t0);
    wait_out(t0, 12, "post_rst_latency");
    take_out("post_rst_pt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 inverse cipher: accepts a 128-bit ciphertext over a valid/ready handshake and returns the plaintext after a fixed 12-cycle schedule. It runs one inverse round per clock: InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. Round keys come from the existing expanded-key store through a one-cycle-latency read port. It is the decrypt-side counterpart of the encryption round datapath and uses the same byte-to-bit state mapping.

## Interface
- NR, 10, number of rounds; fixed for AES-128, other values unsupported.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext valid.
- in_ready  output  1  high only in IDLE.
- in_data  input  128  ciphertext; state byte i = bits 8*i+7:8*i, i = row + 4*col.
- rk_addr  output  4  round-key index, driven directly from the round counter register.
- rk_data  input  128  round key for the rk_addr presented in the previous cycle; same byte mapping.
- out_valid  output  1  plaintext valid; high only in DONE.
- out_ready  input  1  consumer accepts.
- out_data  output  128  plaintext (the state register); stable while out_valid=1.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE. Round counter rnd is 4 bits.
- Reset values:
  - FSM = IDLE, rnd = 10, state register = 0.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0, rk_addr=10.
- IDLE:
  - rk_addr=10.
  - On in_valid & in_ready: latch in_data into ct_q; rnd <= 9; go to INIT.
- INIT: state <= ct_q ^ rk_data (rk[10]); rnd <= 8; go to ROUND.
- ROUND (9 cycles, keys rk[9]..rk[1]):
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - rnd decrements each cycle and saturates at 0.
  - Leave for FINAL after the cycle that consumes rk[1], i.e. the cycle in which rnd==0.
- FINAL: state <= InvSubBytes(InvShiftRows(state)) ^ rk_data (rk[0]); rnd <= 10; go to DONE.
- DONE: hold state; on out_ready go to IDLE.
- InvShiftRows: out[r+4c] = in[r + 4*((c−r) mod 4)]. Row 0 is unchanged; row r rotates right by r columns.
- InvMixColumns, per column: matrix {0e,0b,0d,09} circulant over GF(2^8), polynomial 0x11B.
- in_valid is ignored outside IDLE; in_data is sampled only on handshake.
- rst in any state aborts the operation. No out_valid is produced for the aborted block. Registers return to reset values on that edge.

## Timing
- Handshake accepted at edge ending cycle T.
- INIT occupies T+1, ROUND occupies T+2..T+10, FINAL occupies T+11.
- out_valid=1 from cycle T+12 until the out handshake.
- Latency from accept to out_valid is 12 cycles.
- in_ready rises the cycle after the out handshake, so minimum block period is 13 cycles with out_ready held high.
- rk_addr sequence by cycle: T=10, T+1=9, T+2=8, …, T+10=0, T+11=0, T+12 onward=10.
- out_ready held low keeps DONE and out_data unchanged indefinitely.

## Structure
- Shared package aes_pkg:
  - constants NR=10, STATE_W=128, RK_AW=4.
  - FSM state enum.
  - functions xtime, gf_mul, inv_shift_rows, inv_mix_columns.
- Sub-module inv_sbox: 8-bit combinational 256-entry inverse S-box, instantiated 16× in the datapath.
- No key expansion in this block.

## Test plan
- FIPS-197 C.1: key store holds the expansion of key 000102…0f; ct bytes 0..15 = 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a → out_data bytes 00 11 22 … ff, out_valid at T+12.
- FIPS-197 App. B: key 2b7e1516…4f3c; ct 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32 → pt 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34. Check rk_addr sequence 10,9,…,0,0,10.
- Backpressure: out_ready=0 for 20 cycles. out_valid stays 1 with out_data stable, in_ready=0, and a new in_valid pulse is ignored. After out_ready=1, in_ready=1 the following cycle.
- Back-to-back: the two vectors issued with in_valid and out_ready held high. Accepts occur 13 cycles apart and both results are correct.
- Reset mid-operation: assert rst at T+6 for one cycle. No out_valid appears, and in_ready=1, rk_addr=10, out_data=0 the next cycle. A subsequent C.1 run is correct.
- Reset state: after rst, check in_ready=1, out_valid=0, out_data=0 and rk_addr=10 before any stimulus.
